fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage ARM-subset pipeline, directly upstream of the decode stage and its control unit. Holds the PC, fetches from an instruction memory with a req/ack handshake of variable latency, and drives the IF/ID pipeline register consumed by decode. Honours freeze from hazard detection and branch redirects from EXE, with a one-entry skid buffer so an in-flight fetch is never lost or duplicated.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall: IF/ID register must hold
- branch_taken  in  1  EXE redirect, single-cycle pulse
- branch_addr  in  ADDR_W  redirect target, valid with branch_taken
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, stable while imem_req high
- imem_ack  in  1  data valid this cycle, may coincide with the first req cycle
- imem_rdata  in  INSTR_W  fetched instruction, valid with imem_ack
- pc_out  out  ADDR_W  IF/ID: fetch address + 4
- instr_out  out  INSTR_W  IF/ID: instruction
- valid_out  out  1  IF/ID: instruction is real, not a bubble

## Operation
- States: IDLE, FETCH, BUF, DRAIN. Reset: state IDLE, pc = RESET_PC, pc_out = 0, instr_out = 0, valid_out = 0, skid empty.
- IDLE: imem_req = 0; go to FETCH next cycle.
- FETCH: imem_req = 1, imem_addr = pc.
  - ack, no freeze: IF/ID <= {pc+4, rdata, 1}; pc <= pc+4; stay.
  - ack, freeze: IF/ID holds; skid <= {pc+4, rdata}; pc <= pc+4; go BUF.
  - no ack: stay; req and addr held.
- BUF: imem_req = 0. When freeze drops: IF/ID <= {skid, 1}; go FETCH.
- DRAIN: imem_req = 1 with the discarded address; on ack drop data, go FETCH.
- branch_taken has priority over everything, incl. a simultaneous freeze: pc <= branch_addr; valid_out <= 0, instr_out <= 0; skid cleared. Next state: FETCH if in IDLE/BUF or if ack arrives that cycle (data dropped); DRAIN if in FETCH or DRAIN without ack.
- Freeze with no in-flight ack: IF/ID holds, pc holds, FETCH keeps requesting.
- PC arithmetic modulo 2^ADDR_W: 0xFFFFFFFC + 4 wraps to 0. Low two bits of branch_addr passed through unchanged.

## Timing
- Zero-wait memory (ack in the req cycle): one instruction per clock; first instruction appears in IF/ID two edges after reset release.
- N-cycle memory latency: IF/ID updates on the ack edge.
- Redirect penalty: the edge with branch_taken flushes IF/ID; the target is requested next cycle (after DRAIN completes if a fetch is outstanding).
- Reset asserted mid-fetch: state to IDLE immediately, an outstanding ack after release is ignored (IDLE drives no req).

## Structure
- Shared package fetch_pkg: state enum, NOP/bubble instruction constant (all zeros), PC increment constant 4.
- One sub-module: if_id_reg (pc/instr/valid register with load, hold and flush controls); the FSM, PC and skid stay in fetch_unit.

## Test plan
- Reset release, zero-wait memory returning addr-derived data -> IF/ID pc_out 4, 8, 12 on consecutive cycles, valid_out 1.
- Ack after 3 cycles per request -> imem_addr held stable 3 cycles, one IF/ID update per ack, no duplicates.
- freeze high 4 cycles arriving with an ack at pc 0x10 -> IF/ID holds 0x10 entry; after release pc_out 0x14 loaded from skid, next request 0x14.
- branch_taken to 0x40 while request at 0x20 waits -> DRAIN drops 0x20 data, valid_out 0, next request 0x40, pc_out 0x44.
- branch_taken and freeze in same cycle while in BUF -> skid discarded, valid_out 0, next request branch_addr.
- Reset pulse mid-wait, pc at 0x1C -> imem_req 0 during reset, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, BUF, DRAIN} state_t;
  localparam logic [31:0] NOP_INSTR = '0;
  localparam int PC_INC = 4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus between fetch stage and imem
interface fetch_unit_if #(parameter int ADDR_W = 32, parameter int INSTR_W = 32);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush
module if_id_reg import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out <= '0;
      instr_out <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      instr_out <= INSTR_W'(NOP_INSTR);
      valid_out <= 1'b0;
    end else if (load) begin
      pc_out <= pc_in;
      instr_out <= instr_in;
      valid_out <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem fetch FSM and one-entry skid buffer feeding the IF/ID register
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  fetch_unit_if.master       imem,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_inc, drain_addr, skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic fetch_ack, load;
  assign pc_inc = pc + ADDR_W'(PC_INC);
  assign fetch_ack = state == FETCH && imem.imem_ack;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (branch_taken) state_nx = (imem.imem_req && !imem.imem_ack) ? DRAIN : FETCH;
    else
      unique case (state)
        IDLE:  state_nx = FETCH;
        FETCH: state_nx = (imem.imem_ack && freeze) ? BUF : FETCH;
        BUF:   state_nx = freeze ? BUF : FETCH;
        DRAIN: state_nx = imem.imem_ack ? FETCH : DRAIN;
      endcase
  end
  always_comb begin
    imem.imem_req = state == FETCH || state == DRAIN;
    imem.imem_addr = state == DRAIN ? drain_addr : pc;
    load = !branch_taken && !freeze && (fetch_ack || state == BUF);
  end
  // DRAIN keeps presenting the abandoned address until memory completes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      drain_addr <= '0;
      skid_pc <= '0;
      skid_instr <= '0;
    end else begin
      pc <= branch_taken ? branch_addr : fetch_ack ? pc_inc : pc;
      if (branch_taken && state == FETCH) drain_addr <= pc;
      if (branch_taken) begin
        skid_pc <= '0;
        skid_instr <= '0;
      end else if (fetch_ack && freeze) begin
        skid_pc <= pc_inc;
        skid_instr <= imem.imem_rdata;
      end
    end
  end
  if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(branch_taken),
    .pc_in(state == BUF ? skid_pc : pc_inc),
    .instr_in(state == BUF ? skid_instr : imem.imem_rdata),
    .pc_out(pc_out),
    .instr_out(instr_out),
    .valid_out(valid_out)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, freeze, branch_taken, valid_out;
  logic [31:0] branch_addr, pc_out, instr_out;
  fetch_unit_if bus ();
  fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem(bus), .pc_out(pc_out),
    .instr_out(instr_out), .valid_out(valid_out)
  );
  always #5 clk = ~clk;
  // model: outstanding request, pending drop, next fetch pc, skid queue, expected IF/ID
  bit m_req, m_drop, e_valid, rand_lat;
  logic [31:0] m_addr, nxt, e_pc, e_instr;
  logic [63:0] skid[$];
  int passed, fails, total, wcnt, lat, fix_lat;
  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_out();
    chk("req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("addr", bus.imem_addr, m_addr);
    chk("valid", 32'(valid_out), 32'(e_valid));
    chk("instr", instr_out, e_instr);
    chk("pc_out", pc_out, e_pc);
  endtask
  task automatic cyc(input bit f, input bit b, input logic [31:0] ba);
    bit a, was_req;
    logic [63:0] s;
    chk_out();
    was_req = m_req;
    a = m_req ? (wcnt >= lat) : 1'($urandom_range(0, 1));
    freeze = f;
    branch_taken = b;
    branch_addr = ba;
    bus.imem_ack = a;
    bus.imem_rdata = (a && m_req) ? dat(m_addr) : $urandom;
    if (b) begin
      nxt = ba;
      e_valid = 0;
      e_instr = 0;
      skid.delete();
      if (m_req && !a) m_drop = 1;
      else begin
        m_req = 1;
        m_drop = 0;
        m_addr = ba;
      end
    end else if (!m_req) begin
      if (skid.size() == 0) begin
        m_req = 1;
        m_addr = nxt;
      end else if (!f) begin
        s = skid.pop_front();
        {e_pc, e_instr} = s;
        e_valid = 1;
        m_req = 1;
        m_addr = nxt;
      end
    end else if (a) begin
      if (m_drop) m_drop = 0;
      else begin
        if (f) begin
          skid.push_back({nxt + 32'd4, dat(nxt)});
          m_req = 0;
        end else begin
          e_pc = nxt + 32'd4;
          e_instr = dat(nxt);
          e_valid = 1;
        end
        nxt = nxt + 32'd4;
      end
      m_addr = nxt;
    end
    if (was_req) begin
      if (a) begin
        wcnt = 0;
        lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
      end else wcnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    bus.imem_ack = 1'b1;
    #1;
    m_req = 0; m_drop = 0; nxt = 0; m_addr = 0;
    e_pc = 0; e_instr = 0; e_valid = 0;
    skid.delete();
    wcnt = 0;
    lat = fix_lat;
    repeat (n) begin
      chk_out();
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask
  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    passed = 0; fails = 0; total = 0; fix_lat = 0; rand_lat = 0;
    @(negedge clk);
    do_reset(2);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("zw_pc4", pc_out, 32'h4); chk("zw_valid", 32'(valid_out), 32'd1);
    cyc(0, 0, 0); chk("zw_pc8", pc_out, 32'h8);
    cyc(0, 0, 0); chk("zw_pc12", pc_out, 32'hC);
    fix_lat = 3; lat = 3;
    repeat (12) cyc(0, 0, 0);
    chk("lat3_pc", pc_out, 32'h18);
    fix_lat = 0;
    do_reset(1);
    for (int i = 0; i < 20 && !(m_req && m_addr == 32'h10); i++) cyc(0, 0, 0);
    chk("fz_addr", bus.imem_addr, 32'h10);
    repeat (4) cyc(1, 0, 0);
    chk("fz_hold_pc", pc_out, 32'h10);
    chk("fz_hold_valid", 32'(valid_out), 32'd1);
    cyc(0, 0, 0);
    chk("fz_skid_pc", pc_out, 32'h14);
    chk("fz_next_addr", bus.imem_addr, 32'h14);
    fix_lat = 3; lat = 3;
    for (int i = 0; i < 40 && !(m_req && m_addr == 32'h20 && wcnt == 1); i++) cyc(0, 0, 0);
    chk("br_wait_addr", bus.imem_addr, 32'h20);
    cyc(0, 1, 32'h40);
    chk("br_flush_valid", 32'(valid_out), 32'd0);
    chk("br_drain_addr", bus.imem_addr, 32'h20);
    for (int i = 0; i < 10 && m_addr != 32'h40; i++) cyc(0, 0, 0);
    chk("br_target_addr", bus.imem_addr, 32'h40);
    for (int i = 0; i < 10 && !e_valid; i++) cyc(0, 0, 0);
    chk("br_target_pc", pc_out, 32'h44);
    fix_lat = 0; lat = 0;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 32'h100);
    chk("bf_valid", 32'(valid_out), 32'd0);
    chk("bf_addr", bus.imem_addr, 32'h100);
    fix_lat = 3;
    do_reset(1);
    for (int i = 0; i < 60 && !(m_req && m_addr == 32'h1C && wcnt == 1); i++) cyc(0, 0, 0);
    chk("rs_wait_addr", bus.imem_addr, 32'h1C);
    do_reset(2);
    chk("rs_req", 32'(bus.imem_req), 32'd0);
    fix_lat = 0; lat = 0;
    cyc(0, 0, 0);
    chk("rs_restart", bus.imem_addr, 32'h0);
    cyc(0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    chk("wrap_fc", pc_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap_0", pc_out, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    rand_lat = 1;
    repeat (600) cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom);
    chk_out();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
